// File: rtl/code_ram_instr_responder.sv
// ---------------------------------------------------------------------------
// code_ram_instr_responder
//
// Instruction-bus slave for one code RAM region. It accepts a fetch with the
// core's req/gnt/rvalid handshake and waits WAIT_STATES cycles. It then reads
// one 32-bit word from a synchronous single-port SRAM and returns it as a
// one-cycle rvalid pulse. Only one transaction is outstanding at a time.
//
// Parameters:
//   ADDR_WIDTH  - SRAM word-address width; region is 4*2^ADDR_WIDTH bytes
//   BASE_ADDR   - byte base address of the region, aligned to region size
//   WAIT_STATES - extra cycles between grant and SRAM access (0..15)
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   synchronous active-high reset
//   instr_req     in   fetch request, held until granted
//   instr_addr    in   byte address, stable while instr_req is high
//   instr_gnt     out  request accepted this cycle (combinational)
//   instr_rvalid  out  one-cycle response pulse
//   instr_rdata   out  read data, 0 when instr_rvalid is low
//   instr_err     out  error response, qualified by instr_rvalid
//   mem_req       out  SRAM read enable, one cycle per access
//   mem_addr      out  SRAM word address, 0 when mem_req is low
//   mem_rdata     in   SRAM data, valid the cycle after mem_req
//
// Optional feature, macro CODE_RAM_RESP_ERR_EN:
//   When defined, the responder checks the address at grant time. An address
//   outside the region or one that is not word aligned is answered on the
//   next cycle with instr_err=1 and rdata=0. No SRAM access is made for it.
//   When undefined, addresses alias modulo the region size and instr_err is 0.
// ---------------------------------------------------------------------------
module code_ram_instr_responder #(
    parameter int          ADDR_WIDTH  = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_req,
    input  logic [31:0]           instr_addr,
    output logic                  instr_gnt,
    output logic                  instr_rvalid,
    output logic [31:0]           instr_rdata,
    output logic                  instr_err,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        MEM,
        RESP
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  gnt_int;
    logic                  addr_bad;

`ifdef CODE_RAM_RESP_ERR_EN
    localparam int HI = ADDR_WIDTH + 2;

    logic err_q, err_d;

    // The region is aligned to its own size, so an in-range address is one
    // whose upper bits match the base address.
    assign addr_bad = (instr_addr[31:HI] != BASE_ADDR[31:HI]) ||
                      (instr_addr[1:0] != 2'b00);
`else
    logic unused_cfg;

    // Without the check, only the word-index bits of the address matter.
    assign addr_bad   = 1'b0;
    assign unused_cfg = ^{instr_addr[31:ADDR_WIDTH+2], instr_addr[1:0], BASE_ADDR};
`endif

    // State register. Reset drops any in-flight transaction, so no late
    // mem_req or rvalid can follow it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
`ifdef CODE_RAM_RESP_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
`ifdef CODE_RAM_RESP_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    // Next-state and output logic. A grant can happen in IDLE or in RESP.
    // Both cases share the same accept path below, so back-to-back fetches
    // cost no idle cycle. All outputs are forced low while reset is held.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        gnt_int      = 1'b0;
        instr_rvalid = 1'b0;
        instr_rdata  = '0;
        instr_err    = 1'b0;
        mem_req      = 1'b0;
        mem_addr     = '0;
`ifdef CODE_RAM_RESP_ERR_EN
        err_d        = err_q;
`endif

        case (state_q)
            IDLE: begin
                gnt_int = instr_req;
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = MEM;
                end
            end
            MEM: begin
                mem_req  = 1'b1;
                mem_addr = addr_q;
                state_d  = RESP;
            end
            RESP: begin
                instr_rvalid = 1'b1;
`ifdef CODE_RAM_RESP_ERR_EN
                instr_err    = err_q;
                instr_rdata  = err_q ? 32'd0 : mem_rdata;
`else
                instr_rdata  = mem_rdata;
`endif
                gnt_int      = instr_req;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rst) begin
            gnt_int      = 1'b0;
            instr_rvalid = 1'b0;
            instr_rdata  = '0;
            instr_err    = 1'b0;
            mem_req      = 1'b0;
            mem_addr     = '0;
        end

        // Accept path: latch the word address, then pick the first state of
        // the new transaction.
        if (gnt_int) begin
            addr_d = instr_addr[ADDR_WIDTH+1:2];
`ifdef CODE_RAM_RESP_ERR_EN
            err_d  = 1'b0;
`endif
            if (addr_bad) begin
`ifdef CODE_RAM_RESP_ERR_EN
                err_d = 1'b1;
`endif
                state_d = RESP;
            end else if (WAIT_STATES == 0) begin
                state_d = MEM;
            end else begin
                state_d = WAIT;
                cnt_d   = 4'(WAIT_STATES);
            end
        end
    end

    assign instr_gnt = gnt_int;

endmodule
